// File: rtl/ppu_pkg.sv
// Shared PPU definitions for the sprite evaluator slice.
//   OAM_ENTRIES  : entries scanned per scanline evaluation
//   MAX_SPRITES  : result slots kept per scanline
//   oam_entry_t  : one 32-bit OAM entry {y, tile, attr, x}
//   eval_state_t : evaluator FSM states
package ppu_pkg;
  localparam int OAM_ENTRIES = 64;
  localparam int MAX_SPRITES = 8;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] tile;
    logic [7:0] attr;
    logic [7:0] x;
  } oam_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } eval_state_t;
endpackage

// File: rtl/sprite_evaluator_if.sv
// Bundle of the sprite evaluator request/result and OAM read signals.
//   master : the side that requests evaluations, supplies OAM data and
//            reads back results
//   slave  : the evaluator itself
// Handshake: start is a one-cycle request, honoured only while busy is low;
// done pulses for one cycle when results are final and they stay stable
// until the next accepted start. OAM data follows its address by one cycle.
interface sprite_evaluator_if;
  logic        start;
  logic [7:0]  scanline;
  logic        sprite_size_16;
  logic [5:0]  oam_read_addr;
  logic [31:0] oam_read_data;
  logic        busy;
  logic        done;
  logic [3:0]  sprite_count;
  logic        overflow;
  logic [2:0]  sel_index;
  logic [31:0] sel_entry;
  logic [3:0]  sel_row;

  modport master (
    output start, scanline, sprite_size_16, oam_read_data, sel_index,
    input  oam_read_addr, busy, done, sprite_count, overflow, sel_entry, sel_row
  );

  modport slave (
    input  start, scanline, sprite_size_16, oam_read_data, sel_index,
    output oam_read_addr, busy, done, sprite_count, overflow, sel_entry, sel_row
  );
endinterface

// File: rtl/sprite_range_check.sv
// Combinational vertical range test for one sprite.
//   i_y        : sprite top line
//   i_scanline : line being evaluated
//   i_size_16  : 1 = 16-line sprite, 0 = 8-line sprite
//   o_hit      : sprite covers the scanline
//   o_row      : row inside the sprite (meaningful only when o_hit)
module sprite_range_check (
  input  logic [7:0] i_y,
  input  logic [7:0] i_scanline,
  input  logic       i_size_16,
  output logic       o_hit,
  output logic [3:0] o_row
);
  logic [8:0] w_diff;
  logic [8:0] w_height;

  // 9-bit difference; the >= test below keeps it from being used wrapped.
  assign w_diff   = {1'b0, i_scanline} - {1'b0, i_y};
  assign w_height = i_size_16 ? 9'd16 : 9'd8;
  assign o_hit    = (i_scanline >= i_y) && (w_diff < w_height);
  assign o_row    = w_diff[3:0];
endmodule

// File: rtl/sprite_evaluator.sv
// Scanline sprite evaluator: scans every OAM entry once per request and
// keeps the first MAX_SPRITES entries that cover the requested scanline.
//   clk, reset           : clock, synchronous active-high reset
//   start                : one-cycle request (honoured in IDLE only)
//   scanline, sprite_size_16 : target line and sprite height, latched on start
//   oam_read_addr/data   : OAM read port, data one cycle after address
//   busy, done           : evaluation in progress / one-cycle completion pulse
//   sprite_count, overflow : number of stored hits / more hits than slots
//   sel_index -> sel_entry, sel_row : combinational result slot read
//   dbg_state            : current FSM state
module sprite_evaluator #(
  parameter int OAM_ENTRIES = ppu_pkg::OAM_ENTRIES,
  parameter int MAX_SPRITES = ppu_pkg::MAX_SPRITES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           scanline,
  input  logic                 sprite_size_16,
  output logic [5:0]           oam_read_addr,
  input  logic [31:0]          oam_read_data,
  output logic                 busy,
  output logic                 done,
  output logic [3:0]           sprite_count,
  output logic                 overflow,
  input  logic [2:0]           sel_index,
  output logic [31:0]          sel_entry,
  output logic [3:0]           sel_row,
  output ppu_pkg::eval_state_t dbg_state
);
  import ppu_pkg::*;

  localparam int         SLOT_W     = $clog2(MAX_SPRITES);
  localparam logic [5:0] LAST_ADDR  = 6'(OAM_ENTRIES - 1);
  localparam logic [3:0] SLOT_LIMIT = 4'(MAX_SPRITES);

  eval_state_t r_state;
  eval_state_t w_state_next;
  logic [5:0]  r_addr;
  logic        r_eval_valid;
  logic [7:0]  r_scanline;
  logic        r_size_16;
  logic [3:0]  r_count;
  logic        r_overflow;
  oam_entry_t  r_slot_entry [MAX_SPRITES];
  logic [3:0]  r_slot_row   [MAX_SPRITES];

  oam_entry_t  w_entry;
  logic        w_hit;
  logic [3:0]  w_row;
  logic        w_accept;
  logic        w_store;

  assign w_entry  = oam_entry_t'(oam_read_data);
  assign w_accept = (r_state == ST_IDLE) && start;
  // A hit is kept only while a free slot remains; later hits only flag overflow.
  assign w_store  = r_eval_valid && w_hit && (r_count < SLOT_LIMIT);

  sprite_range_check u_range_check (
    .i_y        (w_entry.y),
    .i_scanline (r_scanline),
    .i_size_16  (r_size_16),
    .o_hit      (w_hit),
    .o_row      (w_row)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b1;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = ST_SCAN;
      end
      ST_SCAN:  if (r_addr == LAST_ADDR) w_state_next = ST_FLUSH;
      ST_FLUSH: w_state_next = ST_DONE;
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr       <= 6'd0;
      r_eval_valid <= 1'b0;
      r_scanline   <= 8'd0;
      r_size_16    <= 1'b0;
      r_count      <= 4'd0;
      r_overflow   <= 1'b0;
    end else begin
      // The address presented during a SCAN cycle has its data next cycle,
      // so the final entry is evaluated during FLUSH.
      r_eval_valid <= (r_state == ST_SCAN);
      r_addr       <= (r_state == ST_SCAN && r_addr != LAST_ADDR) ? r_addr + 6'd1 : 6'd0;
      if (w_accept) begin
        r_count    <= 4'd0;
        r_overflow <= 1'b0;
        r_scanline <= scanline;
        r_size_16  <= sprite_size_16;
      end else if (r_eval_valid && w_hit) begin
        if (r_count < SLOT_LIMIT) r_count    <= r_count + 4'd1;
        else                      r_overflow <= 1'b1;
      end
    end
  end

  // Slot storage is not reset; sprite_count bounds what is visible.
  always_ff @(posedge clk) begin
    if (!reset && w_store) begin
      r_slot_entry[r_count[SLOT_W-1:0]] <= w_entry;
      r_slot_row[r_count[SLOT_W-1:0]]   <= w_row;
    end
  end

  always_comb begin
    sel_entry = 32'hFFFF_FFFF;
    sel_row   = 4'd0;
    if ({1'b0, sel_index} < r_count) begin
      sel_entry = r_slot_entry[sel_index[SLOT_W-1:0]];
      sel_row   = r_slot_row[sel_index[SLOT_W-1:0]];
    end
  end

  assign oam_read_addr = r_addr;
  assign sprite_count  = r_count;
  assign overflow      = r_overflow;
  assign dbg_state     = r_state;
endmodule

// File: tb/tb_sprite_evaluator.sv
// Directed bench for sprite_evaluator. Cycle 0 is the cycle in which start
// is driven; cycle n is the interval following the n-th rising edge after it.
module tb_sprite_evaluator;
  import ppu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_evaluator_if ev_if ();
  eval_state_t dbg_state;

  sprite_evaluator dut (
    .clk            (clk),
    .reset          (reset),
    .start          (ev_if.start),
    .scanline       (ev_if.scanline),
    .sprite_size_16 (ev_if.sprite_size_16),
    .oam_read_addr  (ev_if.oam_read_addr),
    .oam_read_data  (ev_if.oam_read_data),
    .busy           (ev_if.busy),
    .done           (ev_if.done),
    .sprite_count   (ev_if.sprite_count),
    .overflow       (ev_if.overflow),
    .sel_index      (ev_if.sel_index),
    .sel_entry      (ev_if.sel_entry),
    .sel_row        (ev_if.sel_row),
    .dbg_state      (dbg_state)
  );

  // Synchronous OAM model: data follows its address by one cycle.
  logic [31:0] oam [64];
  always @(posedge clk) ev_if.oam_read_data <= oam[ev_if.oam_read_addr];

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_e [8];
  logic [3:0]  exp_r [8];

  function automatic logic [31:0] mk_entry(input int idx, input logic [7:0] y);
    logic [7:0] id;
    id = 8'(idx);
    return {y, id, 8'h5A, ~id};
  endfunction

  task automatic fill_oam(input logic [7:0] y);
    for (int i = 0; i < 64; i++) oam[i] = mk_entry(i, y);
  endtask

  task automatic clear_exp();
    for (int s = 0; s < 8; s++) begin
      exp_e[s] = 32'hFFFF_FFFF;
      exp_r[s] = 4'd0;
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_scan(input logic [7:0] sl, input logic sz,
                          input int pulse_a, input int pulse_b, input int reset_at,
                          output int first_done, output int n_done,
                          output logic busy_c1, output logic [5:0] addr_c1,
                          output logic [5:0] addr_c64, output logic busy_after_rst);
    int cyc;
    logic pulse;
    cyc = 0;
    first_done = -1; n_done = 0; busy_c1 = 1'b0; addr_c1 = 6'h3F;
    addr_c64 = 6'h00; busy_after_rst = 1'b1;
    ev_if.scanline = sl; ev_if.sprite_size_16 = sz; ev_if.start = 1'b1;
    while (cyc < 70) begin
      @(posedge clk); #1; cyc++;
      if (ev_if.done === 1'b1) begin
        n_done++;
        if (first_done < 0) first_done = cyc;
      end
      if (cyc == 1) begin busy_c1 = ev_if.busy; addr_c1 = ev_if.oam_read_addr; end
      if (cyc == 64) addr_c64 = ev_if.oam_read_addr;
      if (cyc == reset_at + 1) busy_after_rst = ev_if.busy;
      pulse = (cyc == pulse_a) || (cyc == pulse_b);
      ev_if.start = pulse;
      // Ignored requests carry different parameters so a wrong accept shows up.
      ev_if.scanline = pulse ? ~sl : sl;
      ev_if.sprite_size_16 = pulse ? ~sz : sz;
      reset = (cyc == reset_at);
    end
    ev_if.start = 1'b0; ev_if.scanline = sl; reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    fill_oam(8'hF0);
    reset = 1'b1; ev_if.start = 1'b0; ev_if.scanline = 8'd0;
    ev_if.sprite_size_16 = 1'b0; ev_if.sel_index = 3'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ev_if.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got %b want 0", ev_if.busy); end
    checks++; if (ev_if.done !== 1'b0) begin failures++; $display("FAIL rst_done got %b want 0", ev_if.done); end
    checks++; if (ev_if.sprite_count !== 4'd0) begin failures++; $display("FAIL rst_count got %0d want 0", ev_if.sprite_count); end
    checks++; if (ev_if.overflow !== 1'b0) begin failures++; $display("FAIL rst_overflow got %b want 0", ev_if.overflow); end
    checks++; if (ev_if.oam_read_addr !== 6'd0) begin failures++; $display("FAIL rst_addr got %0d want 0", ev_if.oam_read_addr); end
    checks++; if (dbg_state !== ST_IDLE) begin failures++; $display("FAIL rst_state got %0d want 0", dbg_state); end
    checks++; if (ev_if.sel_entry !== 32'hFFFF_FFFF) begin failures++; $display("FAIL rst_sel got %h want ffffffff", ev_if.sel_entry); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_empty();
    int fd, nd; logic b1, ba; logic [5:0] a1, a64;
    fill_oam(8'hF0);
    run_scan(8'd10, 1'b0, -1, -1, -1, fd, nd, b1, a1, a64, ba);
    checks++; if (fd !== 66) begin failures++; $display("FAIL empty_done_cycle got %0d want 66", fd); end
    checks++; if (nd !== 1) begin failures++; $display("FAIL empty_done_pulses got %0d want 1", nd); end
    checks++; if (b1 !== 1'b1) begin failures++; $display("FAIL empty_busy_c1 got %b want 1", b1); end
    checks++; if (a1 !== 6'd0) begin failures++; $display("FAIL empty_addr_c1 got %0d want 0", a1); end
    checks++; if (a64 !== 6'd63) begin failures++; $display("FAIL empty_addr_c64 got %0d want 63", a64); end
    checks++; if (ev_if.sprite_count !== 4'd0) begin failures++; $display("FAIL empty_count got %0d want 0", ev_if.sprite_count); end
    checks++; if (ev_if.overflow !== 1'b0) begin failures++; $display("FAIL empty_overflow got %b want 0", ev_if.overflow); end
    checks++; if (ev_if.busy !== 1'b0) begin failures++; $display("FAIL empty_idle_busy got %b want 0", ev_if.busy); end
  endtask

  task automatic test_range();
    int fd, nd; logic b1, ba; logic [5:0] a1, a64;
    fill_oam(8'hF0);
    oam[5] = mk_entry(5, 8'd10); oam[20] = mk_entry(20, 8'd3); oam[63] = mk_entry(63, 8'd17);
    run_scan(8'd17, 1'b0, -1, -1, -1, fd, nd, b1, a1, a64, ba);
    clear_exp();
    exp_e[0] = mk_entry(5, 8'd10);  exp_r[0] = 4'd7;
    exp_e[1] = mk_entry(63, 8'd17); exp_r[1] = 4'd0;
    checks++; if (ev_if.sprite_count !== 4'd2) begin failures++; $display("FAIL range8_count got %0d want 2", ev_if.sprite_count); end
    for (int s = 0; s < 3; s++) begin
      ev_if.sel_index = 3'(s); #1;
      checks++;
      if (ev_if.sel_entry !== exp_e[s] || ev_if.sel_row !== exp_r[s]) begin
        failures++;
        $display("FAIL range8_slot%0d got %h/%0d want %h/%0d", s, ev_if.sel_entry, ev_if.sel_row, exp_e[s], exp_r[s]);
      end
    end
    run_scan(8'd17, 1'b1, -1, -1, -1, fd, nd, b1, a1, a64, ba);
    exp_e[1] = mk_entry(20, 8'd3);  exp_r[1] = 4'd14;
    exp_e[2] = mk_entry(63, 8'd17); exp_r[2] = 4'd0;
    checks++; if (ev_if.sprite_count !== 4'd3) begin failures++; $display("FAIL range16_count got %0d want 3", ev_if.sprite_count); end
    for (int s = 0; s < 4; s++) begin
      ev_if.sel_index = 3'(s); #1;
      checks++;
      if (ev_if.sel_entry !== exp_e[s] || ev_if.sel_row !== exp_r[s]) begin
        failures++;
        $display("FAIL range16_slot%0d got %h/%0d want %h/%0d", s, ev_if.sel_entry, ev_if.sel_row, exp_e[s], exp_r[s]);
      end
    end
  endtask

  task automatic test_overflow();
    int fd, nd; logic b1, ba; logic [5:0] a1, a64;
    fill_oam(8'd100);
    run_scan(8'd100, 1'b0, -1, -1, -1, fd, nd, b1, a1, a64, ba);
    checks++; if (fd !== 66) begin failures++; $display("FAIL ovf_done_cycle got %0d want 66", fd); end
    checks++; if (ev_if.sprite_count !== 4'd8) begin failures++; $display("FAIL ovf_count got %0d want 8", ev_if.sprite_count); end
    checks++; if (ev_if.overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b want 1", ev_if.overflow); end
    for (int s = 0; s < 8; s++) begin
      ev_if.sel_index = 3'(s); #1;
      checks++;
      if (ev_if.sel_entry !== mk_entry(s, 8'd100) || ev_if.sel_row !== 4'd0) begin
        failures++;
        $display("FAIL ovf_slot%0d got %h/%0d want %h/0", s, ev_if.sel_entry, ev_if.sel_row, mk_entry(s, 8'd100));
      end
    end
  endtask

  task automatic test_edges();
    int fd, nd; logic b1, ba; logic [5:0] a1, a64;
    fill_oam(8'hF0);
    oam[0] = mk_entry(0, 8'hFF);
    run_scan(8'd0, 1'b0, -1, -1, -1, fd, nd, b1, a1, a64, ba);
    checks++; if (ev_if.sprite_count !== 4'd0) begin failures++; $display("FAIL edge_nowrap_count got %0d want 0", ev_if.sprite_count); end
    oam[0] = mk_entry(0, 8'hF8);
    run_scan(8'hFF, 1'b0, -1, -1, -1, fd, nd, b1, a1, a64, ba);
    checks++; if (ev_if.sprite_count !== 4'd1) begin failures++; $display("FAIL edge_top_count got %0d want 1", ev_if.sprite_count); end
    ev_if.sel_index = 3'd0; #1;
    checks++;
    if (ev_if.sel_entry !== mk_entry(0, 8'hF8) || ev_if.sel_row !== 4'd7) begin
      failures++;
      $display("FAIL edge_top_slot0 got %h/%0d want %h/7", ev_if.sel_entry, ev_if.sel_row, mk_entry(0, 8'hF8));
    end
    ev_if.sel_index = 3'd1; #1;
    checks++;
    if (ev_if.sel_entry !== 32'hFFFF_FFFF || ev_if.sel_row !== 4'd0) begin
      failures++;
      $display("FAIL edge_empty_slot1 got %h/%0d want ffffffff/0", ev_if.sel_entry, ev_if.sel_row);
    end
  endtask

  task automatic test_reset_mid();
    int fd, nd; logic b1, ba; logic [5:0] a1, a64;
    fill_oam(8'd100);
    run_scan(8'd100, 1'b0, -1, -1, 30, fd, nd, b1, a1, a64, ba);
    checks++; if (nd !== 0) begin failures++; $display("FAIL rstmid_done_pulses got %0d want 0", nd); end
    checks++; if (ba !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %b want 0", ba); end
    checks++; if (ev_if.sprite_count !== 4'd0) begin failures++; $display("FAIL rstmid_count got %0d want 0", ev_if.sprite_count); end
    checks++; if (ev_if.overflow !== 1'b0) begin failures++; $display("FAIL rstmid_overflow got %b want 0", ev_if.overflow); end
    run_scan(8'd100, 1'b0, -1, -1, -1, fd, nd, b1, a1, a64, ba);
    checks++; if (fd !== 66) begin failures++; $display("FAIL rstmid_rerun_done got %0d want 66", fd); end
    checks++; if (ev_if.sprite_count !== 4'd8) begin failures++; $display("FAIL rstmid_rerun_count got %0d want 8", ev_if.sprite_count); end
  endtask

  task automatic test_back_to_back();
    int fd, nd; logic b1, ba; logic [5:0] a1, a64;
    fill_oam(8'hF0);
    oam[5] = mk_entry(5, 8'd10); oam[20] = mk_entry(20, 8'd3); oam[63] = mk_entry(63, 8'd17);
    run_scan(8'd17, 1'b1, 10, 65, -1, fd, nd, b1, a1, a64, ba);
    clear_exp();
    exp_e[0] = mk_entry(5, 8'd10);  exp_r[0] = 4'd7;
    exp_e[1] = mk_entry(20, 8'd3);  exp_r[1] = 4'd14;
    exp_e[2] = mk_entry(63, 8'd17); exp_r[2] = 4'd0;
    checks++; if (nd !== 1) begin failures++; $display("FAIL b2b_done_pulses got %0d want 1", nd); end
    checks++; if (fd !== 66) begin failures++; $display("FAIL b2b_done_cycle got %0d want 66", fd); end
    checks++; if (ev_if.sprite_count !== 4'd3) begin failures++; $display("FAIL b2b_count got %0d want 3", ev_if.sprite_count); end
    for (int s = 0; s < 4; s++) begin
      ev_if.sel_index = 3'(s); #1;
      checks++;
      if (ev_if.sel_entry !== exp_e[s] || ev_if.sel_row !== exp_r[s]) begin
        failures++;
        $display("FAIL b2b_slot%0d got %h/%0d want %h/%0d", s, ev_if.sel_entry, ev_if.sel_row, exp_e[s], exp_r[s]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_empty();
    test_range();
    test_overflow();
    test_edges();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_evaluator.md
SPRITE_EVALUATOR -- requirements
Module: sprite_evaluator

Interface
REQ-001 SHALL have parameter OAM_ENTRIES, default 64: number of 32-bit OAM entries scanned per evaluation.
REQ-002 SHALL have parameter MAX_SPRITES, default 8: number of result slots per scanline.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to evaluate one scanline.
REQ-006 SHALL have port scanline, input, 8 bits: target line, sampled when start is accepted.
REQ-007 SHALL have port sprite_size_16, input, 1 bit: sprite height; 1 = 16 lines, 0 = 8 lines; sampled with start.
REQ-008 SHALL have port oam_read_addr, output, 6 bits: entry address to OAM read port.
REQ-009 SHALL have port oam_read_data, input, 32 bits: OAM entry, valid the cycle after its address.
REQ-010 SHALL have port busy, output, 1 bit: high while evaluation is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when results are final.
REQ-012 SHALL have port sprite_count, output, 4 bits: number of stored hits, 0..8.
REQ-013 SHALL have port overflow, output, 1 bit: more than MAX_SPRITES hits on the line.
REQ-014 SHALL have port sel_index, input, 3 bits: result slot select.
REQ-015 SHALL have port sel_entry, output, 32 bits: combinational read of selected slot.
REQ-016 SHALL have port sel_row, output, 4 bits: row within sprite for selected slot.

Function
REQ-017 SHALL decode each OAM entry as y[31:24], tile[23:16], attr[15:8], x[7:0].
REQ-018 SHALL have FSM states IDLE, SCAN, FLUSH, DONE; transitions IDLE->SCAN on start, SCAN->FLUSH after address 63, FLUSH->DONE, DONE->IDLE.
REQ-019 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-020 SHALL, on accepted start, clear sprite_count and overflow, latch scanline and sprite_size_16, and drive oam_read_addr 0 in the first SCAN cycle.
REQ-021 SHALL increment oam_read_addr by one per SCAN cycle through 63, then hold 0 in FLUSH, DONE and IDLE.
REQ-022 SHALL evaluate the entry for address n in the cycle after n was presented, with one compare per cycle and no stalls.
REQ-023 SHALL treat an entry as a hit when scanline >= y and (scanline - y) < height; subtraction is 9-bit unsigned and never wraps.
REQ-024 SHALL store each hit in the next free slot in ascending OAM order, with row = (scanline - y)[3:0].
REQ-025 SHALL, on the ninth and later hits, set overflow, discard the entry and continue the full scan.
REQ-026 SHALL assert busy in SCAN, FLUSH and DONE, and assert done only in DONE.
REQ-027 SHALL assert done exactly 66 cycles after the edge that accepted start.
REQ-028 SHALL hold results, sprite_count and overflow stable from done until the next accepted start.
REQ-029 SHALL return sel_entry 32'hFFFFFFFF and sel_row 0 when sel_index >= sprite_count.

Reset
REQ-030 SHALL, on reset, force IDLE, oam_read_addr 0, busy 0, done 0, sprite_count 0 and overflow 0; reset takes priority over start.
REQ-031 SHALL abort any evaluation in progress on reset mid-scan without a done pulse; result slot storage need not be reset.

Structure
REQ-032 SHALL take OAM_ENTRIES, MAX_SPRITES, the oam_entry_t packed struct (y, tile, attr, x) and the FSM state enum from shared package ppu_pkg.
REQ-033 SHALL instantiate one combinational sub-module, sprite_range_check, taking y, scanline and size and producing hit and row.

Verification
REQ-034 SHALL cover: all y=0xF0, scanline 10 -> done at cycle 66, sprite_count 0, overflow 0.
REQ-035 SHALL cover: entry5 y=10, entry20 y=3, entry63 y=17, rest 0xF0, scanline 17, size 8 -> count 2 (entry5 row 7, entry63 row 0); size 16 -> count 3 (rows 7, 14, 0 in order).
REQ-036 SHALL cover: all 64 entries y=100, scanline 100 -> count 8, slots hold entries 0..7, overflow 1, done still at cycle 66.
REQ-037 SHALL cover: y=0xFF, scanline 0 -> no hit; y=0xF8, scanline 0xFF, size 8 -> hit with row 7.
REQ-038 SHALL cover: reset at cycle 30 -> busy 0 next cycle, count 0, no done; next start -> normal done at cycle 66.
REQ-039 SHALL cover: start re-pulsed at cycles 10 and 65 -> ignored, a single done at cycle 66, results unchanged.
